// File: rtl/toy_bus_req_arb2_if.sv
// toy_bus_req_arb2_if: request/ack bundle for both core-side ports and the network-side port
interface toy_bus_req_arb2_if;
    logic         in0_req_vld;
    logic         in0_req_rdy;
    logic [31:0]  in0_req_addr;
    logic [255:0] in0_req_data;
    logic [31:0]  in0_req_strb;
    logic         in0_req_opcode;
    logic [3:0]   in0_req_tgt_id;
    logic [9:0]   in0_req_sideband;
    logic         in0_ack_vld;
    logic         in0_ack_rdy;
    logic [255:0] in0_ack_data;
    logic [9:0]   in0_ack_sideband;
    logic         in1_req_vld;
    logic         in1_req_rdy;
    logic [31:0]  in1_req_addr;
    logic [255:0] in1_req_data;
    logic [31:0]  in1_req_strb;
    logic         in1_req_opcode;
    logic [3:0]   in1_req_tgt_id;
    logic [9:0]   in1_req_sideband;
    logic         in1_ack_vld;
    logic         in1_ack_rdy;
    logic [255:0] in1_ack_data;
    logic [9:0]   in1_ack_sideband;
    logic         out0_req_vld;
    logic         out0_req_rdy;
    logic [31:0]  out0_req_addr;
    logic [255:0] out0_req_data;
    logic [31:0]  out0_req_strb;
    logic         out0_req_opcode;
    logic [3:0]   out0_req_tgt_id;
    logic [9:0]   out0_req_sideband;
    logic [3:0]   out0_req_src_id;
    logic         out0_ack_vld;
    logic         out0_ack_rdy;
    logic         out0_ack_opcode;
    logic [255:0] out0_ack_data;
    logic [9:0]   out0_ack_sideband;
    logic [3:0]   out0_ack_src_id;
    logic [3:0]   out0_ack_tgt_id;

    modport slave (
        input  in0_req_vld, in0_req_addr, in0_req_data, in0_req_strb, in0_req_opcode,
               in0_req_tgt_id, in0_req_sideband, in0_ack_rdy,
               in1_req_vld, in1_req_addr, in1_req_data, in1_req_strb, in1_req_opcode,
               in1_req_tgt_id, in1_req_sideband, in1_ack_rdy,
               out0_req_rdy, out0_ack_vld, out0_ack_opcode, out0_ack_data,
               out0_ack_sideband, out0_ack_src_id, out0_ack_tgt_id,
        output in0_req_rdy, in0_ack_vld, in0_ack_data, in0_ack_sideband,
               in1_req_rdy, in1_ack_vld, in1_ack_data, in1_ack_sideband,
               out0_req_vld, out0_req_addr, out0_req_data, out0_req_strb, out0_req_opcode,
               out0_req_tgt_id, out0_req_sideband, out0_req_src_id, out0_ack_rdy
    );

    modport master (
        output in0_req_vld, in0_req_addr, in0_req_data, in0_req_strb, in0_req_opcode,
               in0_req_tgt_id, in0_req_sideband, in0_ack_rdy,
               in1_req_vld, in1_req_addr, in1_req_data, in1_req_strb, in1_req_opcode,
               in1_req_tgt_id, in1_req_sideband, in1_ack_rdy,
               out0_req_rdy, out0_ack_vld, out0_ack_opcode, out0_ack_data,
               out0_ack_sideband, out0_ack_src_id, out0_ack_tgt_id,
        input  in0_req_rdy, in0_ack_vld, in0_ack_data, in0_ack_sideband,
               in1_req_rdy, in1_ack_vld, in1_ack_data, in1_ack_sideband,
               out0_req_vld, out0_req_addr, out0_req_data, out0_req_strb, out0_req_opcode,
               out0_req_tgt_id, out0_req_sideband, out0_req_src_id, out0_ack_rdy
    );
endinterface

// File: rtl/toy_bus_req_arb2.sv
// toy_bus_req_arb2: round-robin 2:1 request arbiter with registered output slot and ack demux
module toy_bus_req_arb2 #(
    parameter logic [3:0] SRC_ID0 = 4'd0,
    parameter logic [3:0] SRC_ID1 = 4'd1,
    parameter int         MAX_OST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    toy_bus_req_arb2_if.slave     bus,
    output logic                  err_ack
);
    localparam logic [3:0] MAX = 4'(MAX_OST);

    logic       rr;
    logic [3:0] ost0, ost1;
    logic       slot_free, elig0, elig1, win0, win1, acc0, acc1;
    logic       sel0, sel1, hs0, hs1, dec0, dec1, unroutable;
    logic       unused_ack;

    assign slot_free = !bus.out0_req_vld || bus.out0_req_rdy;
    assign elig0     = bus.in0_req_vld && ost0 < MAX;
    assign elig1     = bus.in1_req_vld && ost1 < MAX;
    assign win0      = elig0 && (!elig1 || !rr);
    assign win1      = elig1 && (!elig0 || rr);
    assign bus.in0_req_rdy = slot_free && win0;
    assign bus.in1_req_rdy = slot_free && win1;
    assign acc0      = bus.in0_req_rdy;
    assign acc1      = bus.in1_req_rdy;

    assign sel0 = bus.out0_ack_tgt_id == SRC_ID0;
    assign sel1 = !sel0 && bus.out0_ack_tgt_id == SRC_ID1;
    assign bus.in0_ack_vld      = bus.out0_ack_vld && sel0;
    assign bus.in1_ack_vld      = bus.out0_ack_vld && sel1;
    assign bus.in0_ack_data     = bus.out0_ack_data;
    assign bus.in1_ack_data     = bus.out0_ack_data;
    assign bus.in0_ack_sideband = bus.out0_ack_sideband;
    assign bus.in1_ack_sideband = bus.out0_ack_sideband;
    assign bus.out0_ack_rdy     = sel0 ? bus.in0_ack_rdy : sel1 ? bus.in1_ack_rdy : 1'b1;
    assign hs0        = bus.in0_ack_vld && bus.in0_ack_rdy;
    assign hs1        = bus.in1_ack_vld && bus.in1_ack_rdy;
    assign dec0       = hs0 && ost0 != 4'd0;
    assign dec1       = hs1 && ost1 != 4'd0;
    assign unroutable = bus.out0_ack_vld && !sel0 && !sel1;
    assign unused_ack = ^{bus.out0_ack_opcode, bus.out0_ack_src_id};

    // output slot: refill on accept, drain when the network takes it, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out0_req_vld      <= 1'b0;
            bus.out0_req_addr     <= '0;
            bus.out0_req_data     <= '0;
            bus.out0_req_strb     <= '0;
            bus.out0_req_opcode   <= 1'b0;
            bus.out0_req_tgt_id   <= '0;
            bus.out0_req_sideband <= '0;
            bus.out0_req_src_id   <= '0;
        end else if (acc0 || acc1) begin
            bus.out0_req_vld      <= 1'b1;
            bus.out0_req_addr     <= acc1 ? bus.in1_req_addr : bus.in0_req_addr;
            bus.out0_req_data     <= acc1 ? bus.in1_req_data : bus.in0_req_data;
            bus.out0_req_strb     <= acc1 ? bus.in1_req_strb : bus.in0_req_strb;
            bus.out0_req_opcode   <= acc1 ? bus.in1_req_opcode : bus.in0_req_opcode;
            bus.out0_req_tgt_id   <= acc1 ? bus.in1_req_tgt_id : bus.in0_req_tgt_id;
            bus.out0_req_sideband <= acc1 ? bus.in1_req_sideband : bus.in0_req_sideband;
            bus.out0_req_src_id   <= acc1 ? SRC_ID1 : SRC_ID0;
        end else if (bus.out0_req_rdy) begin
            bus.out0_req_vld      <= 1'b0;
        end
    end

    // round-robin pointer hands priority to the other requester after each accept,
    // outstanding counters saturate at zero on unexpected acks, err_ack is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr      <= 1'b0;
            ost0    <= '0;
            ost1    <= '0;
            err_ack <= 1'b0;
        end else begin
            rr      <= acc0 ? 1'b1 : acc1 ? 1'b0 : rr;
            ost0    <= ost0 + {3'b0, acc0} - {3'b0, dec0};
            ost1    <= ost1 + {3'b0, acc1} - {3'b0, dec1};
            err_ack <= err_ack || unroutable || (hs0 && ost0 == 4'd0) || (hs1 && ost1 == 4'd0);
        end
    end
endmodule

// File: tb/tb_toy_bus_req_arb2.sv
// tb_toy_bus_req_arb2: directed scenario bench for the 2:1 request arbiter
module tb_toy_bus_req_arb2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_ack;
    int   checks = 0;
    int   errors = 0;

    toy_bus_req_arb2_if bus();

    toy_bus_req_arb2 #(.SRC_ID0(4'd0), .SRC_ID1(4'd1), .MAX_OST(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .err_ack(err_ack)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.in0_req_vld = 0; bus.in0_req_addr = 0; bus.in0_req_data = 0; bus.in0_req_strb = 0;
        bus.in0_req_opcode = 0; bus.in0_req_tgt_id = 0; bus.in0_req_sideband = 0; bus.in0_ack_rdy = 0;
        bus.in1_req_vld = 0; bus.in1_req_addr = 0; bus.in1_req_data = 0; bus.in1_req_strb = 0;
        bus.in1_req_opcode = 0; bus.in1_req_tgt_id = 0; bus.in1_req_sideband = 0; bus.in1_ack_rdy = 0;
        bus.out0_req_rdy = 0; bus.out0_ack_vld = 0; bus.out0_ack_opcode = 0; bus.out0_ack_data = 0;
        bus.out0_ack_sideband = 0; bus.out0_ack_src_id = 0; bus.out0_ack_tgt_id = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        @(negedge clk);
        checks++; if (bus.out0_req_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b want 0", bus.out0_req_vld); end
        checks++; if (bus.out0_req_addr !== 32'h0 || bus.out0_req_src_id !== 4'h0) begin errors++; $display("FAIL reset_payload got addr=%h src=%0d want 0/0", bus.out0_req_addr, bus.out0_req_src_id); end
        checks++; if (err_ack !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_ack); end
        rst_n = 1;
        bus.in0_req_vld = 1;
        #1;
        checks++; if (bus.in0_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b want 1", bus.in0_req_rdy); end
        bus.in0_req_vld = 0;
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_src [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic [31:0] exp_addr[4] = '{32'h100, 32'h200, 32'h100, 32'h200};
        do_reset();
        bus.in0_req_vld = 1; bus.in0_req_addr = 32'h100;
        bus.in1_req_vld = 1; bus.in1_req_addr = 32'h200;
        bus.out0_req_rdy = 1;
        #1;
        checks++; if (bus.in0_req_rdy !== 1'b1 || bus.in1_req_rdy !== 1'b0) begin errors++; $display("FAIL rr_first_rdy got %0b%0b want 10", bus.in0_req_rdy, bus.in1_req_rdy); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out0_req_vld !== 1'b1 || bus.out0_req_src_id !== exp_src[i] || bus.out0_req_addr !== exp_addr[i]) begin
                errors++;
                $display("FAIL rr_seq%0d got vld=%0b src=%0d addr=%h want 1/%0d/%h", i, bus.out0_req_vld, bus.out0_req_src_id, bus.out0_req_addr, exp_src[i], exp_addr[i]);
            end
        end
        @(negedge clk);
        checks++; if (bus.out0_req_vld !== 1'b0 || bus.in0_req_rdy !== 1'b0 || bus.in1_req_rdy !== 1'b0) begin errors++; $display("FAIL rr_ost_block got vld=%0b rdy=%0b%0b want 0/00", bus.out0_req_vld, bus.in0_req_rdy, bus.in1_req_rdy); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.in0_req_vld = 1; bus.in0_req_addr = 32'h8000_0000; bus.in0_req_data = {8{32'hCAFE_F00D}};
        bus.out0_req_rdy = 0;
        @(negedge clk);
        bus.in0_req_addr = 32'h1234; bus.in0_req_data = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.out0_req_vld !== 1'b1 || bus.out0_req_addr !== 32'h8000_0000 || bus.out0_req_data !== {8{32'hCAFE_F00D}} || bus.in0_req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got vld=%0b addr=%h rdy=%0b want 1/80000000/0", i, bus.out0_req_vld, bus.out0_req_addr, bus.in0_req_rdy);
            end
            @(negedge clk);
        end
        bus.out0_req_rdy = 1;
        #1;
        checks++; if (bus.in0_req_rdy !== 1'b1) begin errors++; $display("FAIL stall_release_rdy got %0b want 1", bus.in0_req_rdy); end
        @(negedge clk);
        checks++; if (bus.out0_req_vld !== 1'b1 || bus.out0_req_addr !== 32'h1234) begin errors++; $display("FAIL stall_next got vld=%0b addr=%h want 1/00001234", bus.out0_req_vld, bus.out0_req_addr); end
        bus.in0_req_vld = 0;
    endtask

    task automatic test_ost_limit();
        do_reset();
        bus.in1_req_vld = 1; bus.in1_req_addr = 32'hA; bus.out0_req_rdy = 1;
        @(negedge clk);
        @(negedge clk);
        bus.in0_req_vld = 1; bus.in0_req_addr = 32'hB;
        #1;
        checks++; if (bus.in1_req_rdy !== 1'b0 || bus.in0_req_rdy !== 1'b1) begin errors++; $display("FAIL ost_block got rdy0=%0b rdy1=%0b want 1/0", bus.in0_req_rdy, bus.in1_req_rdy); end
        @(negedge clk);
        checks++; if (bus.out0_req_src_id !== 4'd0 || bus.out0_req_addr !== 32'hB) begin errors++; $display("FAIL ost_in0_wins got src=%0d addr=%h want 0/0000000b", bus.out0_req_src_id, bus.out0_req_addr); end
        bus.in0_req_vld = 0;
        bus.out0_ack_vld = 1; bus.out0_ack_tgt_id = 4'd1; bus.out0_ack_data = {8{32'h5A5A_0001}}; bus.out0_ack_sideband = 10'h2AB;
        bus.in1_ack_rdy = 1;
        #1;
        checks++; if (bus.in1_ack_vld !== 1'b1 || bus.in0_ack_vld !== 1'b0 || bus.out0_ack_rdy !== 1'b1) begin errors++; $display("FAIL ost_ack_route got v0=%0b v1=%0b rdy=%0b want 0/1/1", bus.in0_ack_vld, bus.in1_ack_vld, bus.out0_ack_rdy); end
        checks++; if (bus.in0_ack_data !== {8{32'h5A5A_0001}} || bus.in1_ack_data !== {8{32'h5A5A_0001}} || bus.in1_ack_sideband !== 10'h2AB) begin errors++; $display("FAIL ost_ack_bcast got d0=%h sb1=%h want broadcast", bus.in0_ack_data[31:0], bus.in1_ack_sideband); end
        checks++; if (bus.in1_req_rdy !== 1'b0) begin errors++; $display("FAIL ost_pre_dec got %0b want 0", bus.in1_req_rdy); end
        @(negedge clk);
        bus.out0_ack_vld = 0;
        #1;
        checks++; if (bus.in1_req_rdy !== 1'b1) begin errors++; $display("FAIL ost_post_dec got %0b want 1", bus.in1_req_rdy); end
        @(negedge clk);
        checks++; if (bus.out0_req_src_id !== 4'd1 || bus.out0_req_vld !== 1'b1) begin errors++; $display("FAIL ost_in1_again got src=%0d vld=%0b want 1/1", bus.out0_req_src_id, bus.out0_req_vld); end
        checks++; if (err_ack !== 1'b0) begin errors++; $display("FAIL ost_no_err got %0b want 0", err_ack); end
        bus.in1_req_vld = 0;
    endtask

    task automatic test_ack_backpressure();
        do_reset();
        bus.in0_req_vld = 1; bus.out0_req_rdy = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.in0_req_rdy !== 1'b0) begin errors++; $display("FAIL bp_full got %0b want 0", bus.in0_req_rdy); end
        bus.out0_ack_vld = 1; bus.out0_ack_tgt_id = 4'd0; bus.in0_ack_rdy = 0;
        #1;
        checks++; if (bus.out0_ack_rdy !== 1'b0 || bus.in0_ack_vld !== 1'b1 || bus.in1_ack_vld !== 1'b0) begin errors++; $display("FAIL bp_stall got rdy=%0b v0=%0b v1=%0b want 0/1/0", bus.out0_ack_rdy, bus.in0_ack_vld, bus.in1_ack_vld); end
        @(negedge clk);
        #1;
        checks++; if (bus.in0_req_rdy !== 1'b0) begin errors++; $display("FAIL bp_no_dec got %0b want 0", bus.in0_req_rdy); end
        bus.in0_ack_rdy = 1;
        #1;
        checks++; if (bus.out0_ack_rdy !== 1'b1) begin errors++; $display("FAIL bp_release got %0b want 1", bus.out0_ack_rdy); end
        @(negedge clk);
        bus.out0_ack_vld = 0;
        #1;
        checks++; if (bus.in0_req_rdy !== 1'b1 || err_ack !== 1'b0) begin errors++; $display("FAIL bp_dec got rdy=%0b err=%0b want 1/0", bus.in0_req_rdy, err_ack); end
        bus.in0_req_vld = 0;
    endtask

    task automatic test_unroutable();
        do_reset();
        bus.out0_ack_vld = 1; bus.out0_ack_tgt_id = 4'd7;
        #1;
        checks++; if (bus.out0_ack_rdy !== 1'b1 || bus.in0_ack_vld !== 1'b0 || bus.in1_ack_vld !== 1'b0) begin errors++; $display("FAIL unr_drain got rdy=%0b v0=%0b v1=%0b want 1/0/0", bus.out0_ack_rdy, bus.in0_ack_vld, bus.in1_ack_vld); end
        checks++; if (err_ack !== 1'b0) begin errors++; $display("FAIL unr_err_early got %0b want 0", err_ack); end
        @(negedge clk);
        bus.out0_ack_vld = 0;
        checks++; if (err_ack !== 1'b1) begin errors++; $display("FAIL unr_err_set got %0b want 1", err_ack); end
        @(negedge clk);
        checks++; if (err_ack !== 1'b1) begin errors++; $display("FAIL unr_err_sticky got %0b want 1", err_ack); end
    endtask

    task automatic test_unexpected_ack();
        do_reset();
        bus.out0_ack_vld = 1; bus.out0_ack_tgt_id = 4'd1; bus.in1_ack_rdy = 1;
        #1;
        checks++; if (bus.in1_ack_vld !== 1'b1) begin errors++; $display("FAIL unexp_deliver got %0b want 1", bus.in1_ack_vld); end
        @(negedge clk);
        bus.out0_ack_vld = 0;
        checks++; if (err_ack !== 1'b1) begin errors++; $display("FAIL unexp_err got %0b want 1", err_ack); end
        bus.in1_req_vld = 1; bus.out0_req_rdy = 1;
        #1;
        checks++; if (bus.in1_req_rdy !== 1'b1) begin errors++; $display("FAIL unexp_sat0 got %0b want 1", bus.in1_req_rdy); end
        @(negedge clk);
        checks++; if (bus.in1_req_rdy !== 1'b1) begin errors++; $display("FAIL unexp_sat1 got %0b want 1", bus.in1_req_rdy); end
        @(negedge clk);
        checks++; if (bus.in1_req_rdy !== 1'b0) begin errors++; $display("FAIL unexp_sat2 got %0b want 0", bus.in1_req_rdy); end
        bus.in1_req_vld = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.in0_req_vld = 1; bus.in0_req_addr = 32'h55; bus.out0_req_rdy = 0;
        @(negedge clk);
        bus.in0_req_vld = 0;
        checks++; if (bus.out0_req_vld !== 1'b1) begin errors++; $display("FAIL mid_loaded got %0b want 1", bus.out0_req_vld); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (bus.out0_req_vld !== 1'b0 || bus.out0_req_addr !== 32'h0) begin errors++; $display("FAIL mid_async got vld=%0b addr=%h want 0/0", bus.out0_req_vld, bus.out0_req_addr); end
        @(negedge clk);
        rst_n = 1;
        bus.in0_req_vld = 1; bus.in1_req_vld = 1; bus.out0_req_rdy = 1;
        #1;
        checks++; if (bus.in0_req_rdy !== 1'b1 || bus.in1_req_rdy !== 1'b0) begin errors++; $display("FAIL mid_rr got rdy=%0b%0b want 10", bus.in0_req_rdy, bus.in1_req_rdy); end
        idle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_ost_limit();
        test_ack_backpressure();
        test_unroutable();
        test_unexpected_ack();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
